spi_audio_master: RTL and testbench

SPI_AUDIO_MASTER -- requirements
Module: spi_audio_master

---
 rtl/spi_audio_master_pkg.sv | 18 +
 rtl/spi_audio_master_if.sv | 29 ++
 rtl/spi_audio_master_sck_gen.sv | 46 ++++
 rtl/spi_audio_master.sv | 145 ++++++++++++++
 tb/tb_spi_audio_master.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_audio_master_pkg.sv
// Shared types and default parameters for the SPI audio master.
// Holds the FSM state enum and the CLK_DIV/NUM_BYTES/GAP defaults.
package spi_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_GAP,
    S_READ,
    S_DONE
  } state_t;

  localparam int unsigned DEF_CLK_DIV    = 4;
  localparam int unsigned DEF_NUM_BYTES  = 2000;
  localparam int unsigned DEF_GAP_CYCLES = 64;

endpackage

// File: rtl/spi_audio_master_if.sv
// Bus bundle of the SPI audio master: control, byte stream, SPI pins.
// master = the SPI master block, slave = its environment.
interface spi_audio_master_if;

  logic       start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;

  modport master (
    input  start, tx_data, tx_valid, miso,
    output tx_ready, sck, ss, mosi,
    output result, result_valid, busy
  );

  modport slave (
    output start, tx_data, tx_valid, miso,
    input  tx_ready, sck, ss, mosi,
    input  result, result_valid, busy
  );

endinterface

// File: rtl/spi_audio_master_sck_gen.sv
// Serial clock generator: CLK_DIV clk cycles low, then CLK_DIV high.
// Ports: clk, reset, i_en, o_sck, o_rise_tick, o_fall_tick.
module spi_sck_gen
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_sck;
  logic       w_wrap;

  assign w_wrap = i_en && (r_cnt == HALF_LAST);

  // Disabled means parked low with the counter at the
  // start of a fresh low half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Ticks mark the clk edge that toggles sck.
  assign o_rise_tick = w_wrap && !r_sck;
  assign o_fall_tick = w_wrap && r_sck;
  assign o_sck       = r_sck;

endmodule

// File: rtl/spi_audio_master.sv
// SPI master: streams NUM_BYTES audio bytes, waits GAP_CYCLES,
// then reads one result byte. Ports: clk, reset, bus (master).
module spi_audio_master
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned NUM_BYTES  = DEF_NUM_BYTES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic          clk,
  input logic          reset,
  spi_audio_master_if.master bus
);

  localparam int unsigned CW = $clog2(NUM_BYTES + 1);
  localparam int unsigned GW =
    (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [CW-1:0] BYTE_LAST = CW'(NUM_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [7:0]    r_result;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_byte_cnt;
  logic [GW-1:0] r_gap;
  logic          r_ss;

  logic w_sck;
  logic w_rise;
  logic w_fall;
  logic w_sck_en;
  logic w_tx_ready;
  logic w_busy;
  logic w_result_valid;
  logic w_last;
  logic w_more;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_sck_en),
    .o_sck      (w_sck),
    .o_rise_tick(w_rise),
    .o_fall_tick(w_fall)
  );

  assign w_last = w_fall && (r_bit == 3'd7);
  assign w_more = r_byte_cnt < BYTE_LAST;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_FETCH;
      S_FETCH: if (bus.tx_valid) w_next = S_SHIFT;
      S_SHIFT:
        if (w_last) w_next = w_more ? S_FETCH : S_GAP;
      S_GAP:   if (r_gap == GAP_LAST) w_next = S_READ;
      S_READ:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sck_en       = 1'b0;
    w_tx_ready     = 1'b0;
    w_result_valid = 1'b0;
    w_busy         = 1'b1;
    unique case (r_state)
      S_IDLE:         w_busy = 1'b0;
      S_FETCH:        w_tx_ready = 1'b1;
      S_SHIFT, S_READ: w_sck_en = 1'b1;
      S_DONE:         w_result_valid = 1'b1;
      default:        ;
    endcase
  end

  // mosi is r_tx[7]: it only moves on load and on sck falls,
  // and is forced to zero after each byte so READ sends 0x00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_result   <= '0;
      r_bit      <= '0;
      r_byte_cnt <= '0;
      r_gap      <= '0;
      r_ss       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (bus.start) r_byte_cnt <= '0;
        S_FETCH:
          if (bus.tx_valid) begin
            r_tx  <= bus.tx_data;
            r_ss  <= 1'b1;
            r_bit <= '0;
          end
        S_SHIFT, S_READ: begin
          if (w_rise) r_rx <= {r_rx[6:0], bus.miso};
          if (w_fall) begin
            r_bit <= r_bit + 3'd1;
            r_tx  <= w_last ? 8'h00 : {r_tx[6:0], 1'b0};
          end
          if (w_last) begin
            if (r_state == S_READ) begin
              r_ss     <= 1'b0;
              r_result <= r_rx;
            end else if (w_more) begin
              r_byte_cnt <= r_byte_cnt + CW'(1);
            end else begin
              r_ss <= 1'b0;
            end
          end
        end
        S_GAP:
          if (r_gap == GAP_LAST) begin
            r_gap <= '0;
            r_ss  <= 1'b1;
            r_bit <= '0;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        default: ;
      endcase
    end
  end

  assign bus.sck          = w_sck;
  assign bus.ss           = r_ss;
  assign bus.mosi         = r_tx[7];
  assign bus.tx_ready     = w_tx_ready;
  assign bus.busy         = w_busy;
  assign bus.result       = r_result;
  assign bus.result_valid = w_result_valid;

endmodule

// File: tb/tb_spi_audio_master.sv
// Bench for spi_audio_master: byte source, SPI slave model,
// pin-timing monitor and frame-level expectations.
module tb_spi_audio_master;

  localparam int CD = 2;
  localparam int NB = 3;
  localparam int GC = 64;
  // One audio byte: one FETCH cycle plus 16*CD shift cycles.
  // busy spans NB*BYTE_CYC + GC + 16*CD + 1 (the +1 is DONE),
  // plus any cycles FETCH spends waiting for tx_valid.
  localparam int BYTE_CYC = 16 * CD + 1;
  localparam int BUSY_CYC = NB * BYTE_CYC + GC + 16 * CD + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_clr = 1'b0;

  spi_audio_master_if bus();

  spi_audio_master #(
    .CLK_DIV   (CD),
    .NUM_BYTES (NB),
    .GAP_CYCLES(GC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // Slave model: shift in mosi on sck rise, drive miso on
  // sck fall / ss rise. Audio-phase miso is random noise.
  logic [7:0] exp_b [0:NB-1];
  logic [7:0] rd_byte;
  logic [7:0] cap [0:15];
  logic [7:0] sh;
  int cap_n, nb, byte_idx, tot_bits;

  always @(posedge bus.sck or posedge reset or posedge mon_clr) begin
    if (reset || mon_clr) begin
      cap_n = 0; nb = 0; byte_idx = 0;
      tot_bits = 0; sh = 8'h00;
    end else begin
      sh = {sh[6:0], bus.mosi};
      nb++;
      tot_bits++;
      if (nb == 8) begin
        if (cap_n < 16) cap[cap_n] = sh;
        cap_n++;
        nb = 0;
        byte_idx++;
      end
    end
  end

  always @(negedge bus.sck or posedge bus.ss) begin
    if (byte_idx == NB && nb < 8)
      bus.miso = rd_byte[3'(7 - nb)];
    else
      bus.miso = 1'($urandom);
  end

  // Pin monitor, sampled on the inactive clk edge.
  logic prev_sck, prev_ss, rv_prev;
  int hi_run, lo_run, ss_lo_run, rises, n_hi;
  int n_bad_hi, n_bad_lo, ss_bad, gap_len;
  int busy_cyc, acc_n, rv_n, busy_after_rv;
  logic [7:0] last_result;

  always @(negedge clk) begin
    if (reset || mon_clr) begin
      prev_sck = 0; prev_ss = 0; rv_prev = 0;
      hi_run = 0; lo_run = 0; ss_lo_run = 0;
      rises = 0; n_hi = 0; n_bad_hi = 0;
      n_bad_lo = 0; ss_bad = 0; gap_len = -1;
      busy_cyc = 0; acc_n = 0; rv_n = 0;
      busy_after_rv = 1; last_result = 8'h00;
    end else begin
      if (bus.sck) begin
        if (!prev_sck) begin
          if (rises % 8 != 0 && lo_run != CD) n_bad_lo++;
          if (!bus.ss) ss_bad++;
          rises++;
          hi_run = 1;
        end else hi_run++;
      end else begin
        if (prev_sck) begin
          if (hi_run != CD) n_bad_hi++;
          n_hi++;
          lo_run = 1;
        end else lo_run++;
      end
      if (bus.ss) begin
        if (!prev_ss && rises == NB * 8) gap_len = ss_lo_run;
      end else begin
        ss_lo_run = prev_ss ? 1 : ss_lo_run + 1;
      end
      if (bus.busy) busy_cyc++;
      if (bus.tx_valid && bus.tx_ready) acc_n++;
      if (rv_prev) busy_after_rv = int'(bus.busy);
      if (bus.result_valid) begin
        rv_n++;
        last_result = bus.result;
      end
      rv_prev = bus.result_valid;
      prev_sck = bus.sck;
      prev_ss = bus.ss;
    end
  end

  task automatic run_frame(input int stall_k, input int stall_n,
                           input int dup_k, input int abort_bits);
    int w;
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
    bus.tx_data = exp_b[0];
    bus.tx_valid = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) begin
        if (k == stall_k) begin
          bus.tx_valid = 1'b0;
          w = 0;
          do begin @(negedge clk); w++; end
          while (!bus.tx_ready && w < 300);
          check("stall_ready", bus.tx_ready, 1);
          repeat (stall_n) @(posedge clk);
          #1;
          check("stall_sck", bus.sck, 0);
          check("stall_ss", bus.ss, 1);
          bus.tx_valid = 1'b1;
        end
        bus.tx_data = exp_b[k];
      end
      w = 0;
      @(negedge clk);
      while (!bus.tx_ready && w < 300) begin
        @(negedge clk); w++;
      end
      check("accept", bus.tx_ready, 1);
      @(posedge clk); #1;
      if (k == dup_k) begin
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
      end
      if (abort_bits > 0 && k == 1) begin
        w = 0;
        while (tot_bits < abort_bits && w < 300) begin
          @(negedge clk); w++;
        end
        check("abort_point", tot_bits, abort_bits);
        @(negedge clk);
        reset = 1'b1;
        bus.tx_valid = 1'b0;
        return;
      end
    end
    bus.tx_valid = 1'b0;
    w = 0;
    while (bus.busy && w < 5000) begin
      @(negedge clk); w++;
    end
    check("frame_end", bus.busy, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_frame(input int extra);
    check("n_bytes", cap_n, NB + 1);
    for (int k = 0; k < NB; k++)
      check($sformatf("byte%0d", k), cap[k], exp_b[k]);
    check("read_mosi", cap[NB], 8'h00);
    check("sck_rises", tot_bits, 8 * (NB + 1));
    check("hi_runs", n_hi, 8 * (NB + 1));
    check("sck_hi_len", n_bad_hi, 0);
    check("sck_lo_len", n_bad_lo, 0);
    check("ss_at_rise", ss_bad, 0);
    check("gap_len", gap_len, GC);
    check("accepts", acc_n, NB);
    check("rv_pulses", rv_n, 1);
    check("rv_result", last_result, rd_byte);
    check("result", bus.result, rd_byte);
    check("busy_after_rv", busy_after_rv, 0);
    check("busy_cycles", busy_cyc, BUSY_CYC + extra);
  endtask

  task automatic rand_bytes();
    for (int k = 0; k < NB; k++) exp_b[k] = 8'($urandom);
    rd_byte = 8'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int sk, sn;
    bus.start = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    rd_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", bus.sck, 0);
    check("rst_ss", bus.ss, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_ready", bus.tx_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    check("rst_rv", bus.result_valid, 0);
    @(negedge clk) reset = 1'b0;

    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'hFF;
    rd_byte = 8'h07;
    run_frame(-1, 0, -1, 0);
    check_frame(0);

    rand_bytes();
    run_frame(1, 10, -1, 0);
    check_frame(10);

    rand_bytes();
    run_frame(-1, 0, 1, 0);
    check_frame(0);

    rand_bytes();
    run_frame(-1, 0, -1, 13);
    @(posedge clk); #1;
    check("abort_sck", bus.sck, 0);
    check("abort_ss", bus.ss, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_mosi", bus.mosi, 0);
    check("abort_ready", bus.tx_ready, 0);
    check("abort_rv", bus.result_valid, 0);
    check("abort_result", bus.result, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("no_resume_busy", busy_cyc, 0);
    check("no_resume_bits", tot_bits, 0);

    exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'hFF;
    rd_byte = 8'h07;
    run_frame(-1, 0, -1, 0);
    check_frame(0);

    for (int f = 0; f < 4; f++) begin
      rand_bytes();
      sk = $urandom_range(0, NB - 1);
      sn = $urandom_range(1, 20);
      run_frame(sk, sn, -1, 0);
      check_frame(sk > 0 ? sn : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
